// File: rtl/updown_bcd_display.sv
// Multi-digit up/down counter with per-digit radix, clamped load, wrap/saturate at the
// terminal value, and a time-multiplexed seven-segment driver for the scanned digit.
module updown_bcd_display #(
   parameter int DIGITS      = 4,
   parameter int BASE        = 10,
   parameter int WRAP        = 1,
   parameter int SEG_ACT_LOW = 1,
   parameter int SCAN_DIV    = 1024
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_n_i,
   input  logic                en_i,
   input  logic                up_i,
   input  logic                load_i,
   input  logic [4*DIGITS-1:0] load_val_i,
   output logic [4*DIGITS-1:0] count_o,
   output logic                tc_o,
   output logic [6:0]          seg_o,
   output logic [DIGITS-1:0]   dig_sel_o
);

   localparam logic [3:0]    DMAX = 4'(BASE - 1);
   localparam int            PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int            IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);

   logic [4*DIGITS-1:0] count_q;
   logic [4*DIGITS-1:0] step_val;
   logic [4*DIGITS-1:0] load_clamped;
   logic                tc_q;
   logic                at_term;
   logic                carry;
   logic [3:0]          d;
   logic [PW-1:0]       presc_q;
   logic [IW-1:0]       scan_q;
   logic [3:0]          cur_digit;
   logic [6:0]          seg_low;

   // Ripple carry/borrow chain; at the terminal value it naturally yields the wrapped value.
   always_comb begin
      step_val     = count_q;
      load_clamped = load_val_i;
      carry        = 1'b1;
      at_term      = 1'b1;
      d            = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         d = count_q[4*i +: 4];
         if (up_i ? (d != DMAX) : (d != 4'd0)) at_term = 1'b0;
         if (carry) begin
            if (up_i) begin
               if (d == DMAX) begin
                  step_val[4*i +: 4] = 4'd0;
               end else begin
                  step_val[4*i +: 4] = d + 4'd1;
                  carry              = 1'b0;
               end
            end else begin
               if (d == 4'd0) begin
                  step_val[4*i +: 4] = DMAX;
               end else begin
                  step_val[4*i +: 4] = d - 4'd1;
                  carry              = 1'b0;
               end
            end
         end
         if (load_val_i[4*i +: 4] > DMAX) load_clamped[4*i +: 4] = DMAX;
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         count_q <= '0;
         tc_q    <= 1'b0;
      end else if (load_i) begin
         count_q <= load_clamped;
         tc_q    <= 1'b0;
      end else if (en_i) begin
         tc_q <= at_term;
         if (!at_term || (WRAP != 0)) count_q <= step_val;
      end else begin
         tc_q <= 1'b0;
      end
   end

   // Free-running scan: the index advances once per SCAN_DIV clocks.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         presc_q <= '0;
         scan_q  <= '0;
      end else if (presc_q == PMAX) begin
         presc_q <= '0;
         scan_q  <= (scan_q == IMAX) ? '0 : scan_q + IW'(1);
      end else begin
         presc_q <= presc_q + PW'(1);
      end
   end

   always_comb begin
      cur_digit = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (scan_q == IW'(i)) cur_digit = count_q[4*i +: 4];
      end
   end

   always_comb begin
      case (cur_digit)
         4'h0:    seg_low = 7'b0000001;
         4'h1:    seg_low = 7'b1001111;
         4'h2:    seg_low = 7'b0010010;
         4'h3:    seg_low = 7'b0000110;
         4'h4:    seg_low = 7'b1001100;
         4'h5:    seg_low = 7'b0100100;
         4'h6:    seg_low = 7'b0100000;
         4'h7:    seg_low = 7'b0001111;
         4'h8:    seg_low = 7'b0000000;
         4'h9:    seg_low = 7'b0000100;
         4'hA:    seg_low = 7'b0001000;
         4'hB:    seg_low = 7'b1100000;
         4'hC:    seg_low = 7'b0110001;
         4'hD:    seg_low = 7'b1000010;
         4'hE:    seg_low = 7'b0110000;
         default: seg_low = 7'b0111000;
      endcase
   end

   assign seg_o     = (SEG_ACT_LOW != 0) ? seg_low : ~seg_low;
   assign dig_sel_o = DIGITS'(1) << scan_q;
   assign count_o   = count_q;
   assign tc_o      = tc_q;

endmodule

// File: tb/tb_updown_bcd_display.sv
// Bench for updown_bcd_display: a wrapping and a saturating instance (BCD, 4 digits, scan
// every 4 clocks) checked against a decimal-integer model through expected-value queues.
module tb_updown_bcd_display;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        up;
   logic        load;
   logic [15:0] load_val;

   logic [15:0] cnt_w, cnt_s;
   logic        tc_w, tc_s;
   logic [6:0]  seg_w, seg_s;
   logic [3:0]  sel_w, sel_s;

   int errors = 0;
   int checks = 0;

   // Model state: decimal value of each instance and its expected terminal flag.
   int mw = 0;
   int ms = 0;
   logic tw = 1'b0;
   logic ts = 1'b0;

   logic [16:0] exp_q[$];
   logic [16:0] exp_s_q[$];
   logic [16:0] e;

   updown_bcd_display #(.DIGITS(4), .BASE(10), .WRAP(1), .SEG_ACT_LOW(1), .SCAN_DIV(4)) dut_w (
      .wb_clk_i(clk), .wb_rst_n_i(rst_n), .en_i(en), .up_i(up), .load_i(load),
      .load_val_i(load_val), .count_o(cnt_w), .tc_o(tc_w), .seg_o(seg_w), .dig_sel_o(sel_w));

   updown_bcd_display #(.DIGITS(4), .BASE(10), .WRAP(0), .SEG_ACT_LOW(1), .SCAN_DIV(4)) dut_s (
      .wb_clk_i(clk), .wb_rst_n_i(rst_n), .en_i(en), .up_i(up), .load_i(load),
      .load_val_i(load_val), .count_o(cnt_s), .tc_o(tc_s), .seg_o(seg_s), .dig_sel_o(sel_s));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] bcd(input int v);
      logic [15:0] r;
      int x;
      x = v;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic int clamp_val(input logic [15:0] v);
      int acc, m, dd;
      acc = 0;
      m   = 1;
      for (int i = 0; i < 4; i++) begin
         dd = int'(v[4*i +: 4]);
         if (dd > 9) dd = 9;
         acc = acc + dd * m;
         m   = m * 10;
      end
      return acc;
   endfunction

   function automatic logic [6:0] seg_tab(input logic [3:0] n);
      case (n)
         4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
         4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
         4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
         4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
         4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
         4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
         4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
         4'hE: return 7'b0110000;  default: return 7'b0111000;
      endcase
   endfunction

   // Drive one clock of stimulus, advance the models and queue the expected outputs.
   task automatic step(input logic e_i, input logic u_i, input logic l_i, input logic [15:0] v_i);
      @(negedge clk);
      en = e_i; up = u_i; load = l_i; load_val = v_i;
      if (l_i) begin
         mw = clamp_val(v_i); ms = mw; tw = 1'b0; ts = 1'b0;
      end else if (e_i) begin
         if (u_i) begin
            tw = (mw == 9999); mw = (mw + 1) % 10000;
            ts = (ms == 9999); if (!ts) ms = ms + 1;
         end else begin
            tw = (mw == 0); mw = (mw + 9999) % 10000;
            ts = (ms == 0); if (!ts) ms = ms - 1;
         end
      end else begin
         tw = 1'b0; ts = 1'b0;
      end
      exp_q.push_back({tw, bcd(mw)});
      exp_s_q.push_back({ts, bcd(ms)});
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
      mw = 0; ms = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         en = 1'($urandom_range(0, 1)); up = 1'($urandom_range(0, 1));
         load = 1'($urandom_range(0, 1)); load_val = 16'($urandom_range(0, 65535));
         @(posedge clk);
         #1;
         checks++;
         if ({tc_w, cnt_w, sel_w, seg_w} !== {1'b0, 16'h0000, 4'b0001, 7'b0000001}) begin
            errors++;
            $display("FAIL reset_w: got tc=%b cnt=%h sel=%b seg=%b want 0 0000 0001 0000001",
                     tc_w, cnt_w, sel_w, seg_w);
         end
         checks++;
         if ({tc_s, cnt_s, sel_s, seg_s} !== {1'b0, 16'h0000, 4'b0001, 7'b0000001}) begin
            errors++;
            $display("FAIL reset_s: got tc=%b cnt=%h sel=%b seg=%b want 0 0000 0001 0000001",
                     tc_s, cnt_s, sel_s, seg_s);
         end
      end
      en = 1'b0; load = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_carry;
      step(1'b0, 1'b1, 1'b1, 16'h0099);
      step(1'b1, 1'b1, 1'b0, 16'h0000);
      step(1'b1, 1'b1, 1'b0, 16'h0000);
      for (int k = 0; k < 3; k++) begin
         e = exp_q.pop_front();
         void'(exp_s_q.pop_front());
         checks++;
         if ({tc_w, cnt_w} !== e && k == 2) begin
            errors++;
            $display("FAIL carry: got tc=%b cnt=%h want tc=%b cnt=%h", tc_w, cnt_w, e[16], e[15:0]);
         end
      end
      checks++;
      if (cnt_w !== 16'h0101) begin
         errors++;
         $display("FAIL carry_final: got %h want 0101", cnt_w);
      end
   endtask

   // Each step is compared immediately so every intermediate value is checked.
   task automatic run_checked(input string name, input logic e_i, input logic u_i,
                              input logic l_i, input logic [15:0] v_i);
      step(e_i, u_i, l_i, v_i);
      e = exp_q.pop_front();
      checks++;
      if ({tc_w, cnt_w} !== e) begin
         errors++;
         $display("FAIL %s_w: got tc=%b cnt=%h want tc=%b cnt=%h", name, tc_w, cnt_w, e[16], e[15:0]);
      end
      e = exp_s_q.pop_front();
      checks++;
      if ({tc_s, cnt_s} !== e) begin
         errors++;
         $display("FAIL %s_s: got tc=%b cnt=%h want tc=%b cnt=%h", name, tc_s, cnt_s, e[16], e[15:0]);
      end
   endtask

   task automatic test_wrap;
      run_checked("wrap_load", 1'b0, 1'b1, 1'b1, 16'h9999);
      run_checked("wrap_up", 1'b1, 1'b1, 1'b0, 16'h0000);
      checks++;
      if ({tc_w, cnt_w} !== {1'b1, 16'h0000}) begin
         errors++;
         $display("FAIL wrap_up_const: got tc=%b cnt=%h want 1 0000", tc_w, cnt_w);
      end
      run_checked("wrap_down", 1'b1, 1'b0, 1'b0, 16'h0000);
      checks++;
      if ({tc_w, cnt_w} !== {1'b1, 16'h9999}) begin
         errors++;
         $display("FAIL wrap_down_const: got tc=%b cnt=%h want 1 9999", tc_w, cnt_w);
      end
      run_checked("wrap_idle", 1'b0, 1'b0, 1'b0, 16'h0000);
   endtask

   task automatic test_saturate;
      run_checked("sat_load", 1'b0, 1'b0, 1'b1, 16'h0000);
      for (int k = 0; k < 3; k++) begin
         run_checked("sat_down", 1'b1, 1'b0, 1'b0, 16'h0000);
         checks++;
         if ({tc_s, cnt_s} !== {1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL sat_hold: got tc=%b cnt=%h want 1 0000", tc_s, cnt_s);
         end
      end
      run_checked("sat_release", 1'b1, 1'b1, 1'b0, 16'h0000);
   endtask

   task automatic test_clamp;
      run_checked("clamp", 1'b1, 1'b1, 1'b1, 16'h0F3A);
      checks++;
      if ({tc_w, cnt_w, cnt_s} !== {1'b0, 16'h0939, 16'h0939}) begin
         errors++;
         $display("FAIL clamp_const: got tc=%b w=%h s=%h want 0 0939 0939", tc_w, cnt_w, cnt_s);
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] v;
      for (int k = 0; k < 150; k++) begin
         case ($urandom_range(0, 9))
            0:       v = 16'h9999;
            1:       v = 16'h0000;
            default: v = 16'($urandom_range(0, 65535));
         endcase
         run_checked("random", 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 9) == 0), v);
      end
   endtask

   task automatic test_scan;
      logic [15:0] cur;
      logic [3:0]  want_sel;
      logic [6:0]  want_seg;
      int          idx;
      @(negedge clk);
      rst_n = 1'b0; en = 1'b0; load = 1'b0;
      mw = 0; ms = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 1; k <= 21; k++) begin
         if (k == 1) run_checked("scan_load", 1'b0, 1'b1, 1'b1, 16'h1234);
         else        run_checked("scan_hold", 1'b0, 1'b1, 1'b0, 16'h0000);
         idx      = (k / 4) % 4;
         cur      = bcd(mw);
         want_sel = 4'(1 << idx);
         want_seg = seg_tab(cur[4*idx +: 4]);
         checks++;
         if ({sel_w, seg_w, sel_s, seg_s} !== {want_sel, want_seg, want_sel, want_seg}) begin
            errors++;
            $display("FAIL scan k=%0d: got sel=%b seg=%b (s: %b %b) want sel=%b seg=%b",
                     k, sel_w, seg_w, sel_s, seg_s, want_sel, want_seg);
         end
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({sel_w, seg_w, cnt_w, tc_w, sel_s, cnt_s} !==
          {4'b0001, 7'b0000001, 16'h0000, 1'b0, 4'b0001, 16'h0000}) begin
         errors++;
         $display("FAIL scan_reset: got sel=%b seg=%b cnt=%h tc=%b s_sel=%b s_cnt=%h",
                  sel_w, seg_w, cnt_w, tc_w, sel_s, cnt_s);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      mw = 0; ms = 0;
   endtask

   initial begin
      test_reset();
      test_carry();
      test_wrap();
      test_saturate();
      test_clamp();
      test_back_to_back();
      test_scan();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
